// File: rtl/ed25519_pkg.sv
// ed25519_pkg: constants, FSM state type and mod-p helpers shared by proj_to_affine and mod_mul
//   W        coordinate width
//   P        field prime 2^255 - 19
//   mod_red  one conditional subtract of p (enough for any W-bit value)
//   mod_add  (a + b) mod p for a, b < p
//   mod_sub  (a - b) mod p for a, b < p, adding p on borrow
//   mod_half a / 2 mod p for a < p
package ed25519_pkg;
    localparam int W = 255;
    localparam logic [W-1:0] P = {{(W-8){1'b1}}, 8'hED};

    typedef enum logic [1:0] {S_IDLE, S_INV, S_MUL_X, S_MUL_Y} p2a_state_t;

    function automatic logic [W-1:0] mod_red(input logic [W-1:0] a);
        return a >= P ? a - P : a;
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s >= {1'b0, P} ? W'(s - {1'b0, P}) : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[W] ? W'(d + {1'b0, P}) : d[W-1:0];
    endfunction

    // odd values borrow p first so the halving stays exact; the W+1-bit sum cannot overflow
    function automatic logic [W-1:0] mod_half(input logic [W-1:0] a);
        return a[0] ? W'(({1'b0, a} + {1'b0, P}) >> 1) : a >> 1;
    endfunction
endpackage

// File: rtl/proj_to_affine_mod_mul.sv
// mod_mul: bit-serial interleaved modular multiplier, o_p = i_a * i_b mod p
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_start       load operands (i_a, i_b < p); ignored while a product is running
//   i_a, i_b      operands
//   o_p           accumulator; holds the product from o_done until the next start
//   o_done        one-cycle pulse, high 256 cycles after i_start
module mod_mul
    import ed25519_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p,
    output logic         o_done
);
    logic [W-1:0] a, b, dbl, nxt;
    logic [7:0] k;
    logic busy;

    // MSB-first: acc = 2*acc mod p, then + a mod p when b[k] is set
    always_comb begin
        dbl = mod_add(o_p, o_p);
        nxt = b[k] ? mod_add(dbl, a) : dbl;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a      <= '0;
            b      <= '0;
            k      <= '0;
            busy   <= 1'b0;
            o_p    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start && !busy) begin
                a    <= i_a;
                b    <= i_b;
                o_p  <= '0;
                k    <= 8'(W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                o_p <= nxt;
                k   <= k - 8'd1;
                if (k == 8'd0) begin
                    busy   <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/proj_to_affine.sv
// proj_to_affine: projective (X, Y, Z) to affine (X/Z, Y/Z) mod 2^255-19
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             start pulse, accepted only when idle
//   i_x, i_y, i_z       projective inputs, any W-bit value
//   o_x, o_y            affine result, held until the next completion (reset 0, 1)
//   o_finished          one-cycle pulse when o_x/o_y/o_err are valid
//   o_err               with o_finished: Z was 0 mod p, result forced to (0, 0)
//   o_busy              high whenever not idle
module proj_to_affine #(
    parameter int W = ed25519_pkg::W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    output logic [W-1:0] o_x,
    output logic [W-1:0] o_y,
    output logic         o_finished,
    output logic         o_err,
    output logic         o_busy
);
    import ed25519_pkg::*;

    p2a_state_t state;
    logic [W-1:0] x_r, y_r, u, v, x1, x2, inv, xp, mul_a, mul_p;
    logic start_q, mul_start, mul_done;

    // the first product is started from a register one cycle after the inverse is
    // known; the second starts in the very cycle the first completes, operand Y
    assign mul_start = start_q | (state == S_MUL_X && mul_done);
    assign mul_a     = mul_done ? y_r : x_r;
    assign o_busy    = state != S_IDLE;

    mod_mul u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (mul_start),
        .i_a     (mul_a),
        .i_b     (inv),
        .o_p     (mul_p),
        .o_done  (mul_done)
    );

    // binary extended Euclid keeps x1*Z == u and x2*Z == v (mod p)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            x_r        <= '0;
            y_r        <= '0;
            u          <= '0;
            v          <= '0;
            x1         <= '0;
            x2         <= '0;
            inv        <= '0;
            xp         <= '0;
            start_q    <= 1'b0;
            o_x        <= '0;
            o_y        <= W'(1);
            o_finished <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            o_err      <= 1'b0;
            start_q    <= 1'b0;
            case (state)
                S_IDLE: if (i_start) begin
                    x_r   <= mod_red(i_x);
                    y_r   <= mod_red(i_y);
                    u     <= mod_red(i_z);
                    v     <= P;
                    x1    <= W'(1);
                    x2    <= '0;
                    state <= S_INV;
                end
                S_INV: begin
                    if (u == '0) begin
                        o_x        <= '0;
                        o_y        <= '0;
                        o_finished <= 1'b1;
                        o_err      <= 1'b1;
                        state      <= S_IDLE;
                    end else if (u == W'(1) || v == W'(1)) begin
                        inv     <= u == W'(1) ? x1 : x2;
                        start_q <= 1'b1;
                        state   <= S_MUL_X;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= mod_half(x1);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= mod_half(x2);
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= mod_sub(x1, x2);
                    end else begin
                        v  <= v - u;
                        x2 <= mod_sub(x2, x1);
                    end
                end
                S_MUL_X: if (mul_done) begin
                    xp    <= mul_p;
                    state <= S_MUL_Y;
                end
                S_MUL_Y: if (mul_done) begin
                    o_x        <= xp;
                    o_y        <= mul_p;
                    o_finished <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_proj_to_affine.sv
// tb_proj_to_affine: directed vector table plus robustness sequences for proj_to_affine
module tb_proj_to_affine;
    localparam int W = 255;
    localparam logic [W-1:0] P = {{(W-8){1'b1}}, 8'hED};
    localparam logic [255:0] BX256 = 256'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A;
    localparam logic [255:0] BY256 = 256'h6666666666666666666666666666666666666666666666666666666666666658;
    localparam logic [W-1:0] BX = BX256[W-1:0];
    localparam logic [W-1:0] BY = BY256[W-1:0];

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_start = 1'b0;
    logic [W-1:0] i_x = '0, i_y = '0, i_z = '0;
    logic [W-1:0] o_x, o_y;
    logic o_finished, o_err, o_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] x, y, z, ex, ey;
        logic eerr;
        int ecyc;
    } vec_t;

    vec_t vecs[$];

    proj_to_affine #(.W(W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_z        (i_z),
        .o_x        (o_x),
        .o_y        (o_y),
        .o_finished (o_finished),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [W-1:0] red(input logic [W-1:0] a);
        return a >= P ? a - P : a;
    endfunction

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [511:0] t;
        t = ({257'b0, a} * {257'b0, b}) % {257'b0, P};
        return t[W-1:0];
    endfunction

    // Fermat: z^(p-2)
    function automatic logic [W-1:0] invmod(input logic [W-1:0] z);
        logic [W-1:0] r, b, e;
        r = W'(1);
        b = red(z);
        e = P - W'(2);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = mulmod(r, b);
            b = mulmod(b, b);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [255:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                                input logic [W-1:0] ex, input logic [W-1:0] ey, input logic eerr, input int ecyc);
        vec_t t;
        t.x = x; t.y = y; t.z = z; t.ex = ex; t.ey = ey; t.eerr = eerr; t.ecyc = ecyc;
        return t;
    endfunction

    function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        logic [W-1:0] zi;
        if (red(z) == '0) return mk(x, y, z, '0, '0, 1'b1, 2);
        zi = invmod(z);
        return mk(x, y, z, mulmod(red(x), zi), mulmod(red(y), zi), 1'b0, 0);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // cyc = index of the cycle in which o_finished is seen high (start sampled in cycle 0)
    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                       output int cyc, output logic ok);
        @(negedge i_clk);
        i_x = x; i_y = y; i_z = z; i_start = 1'b1;
        cyc = 0;
        ok = 1'b0;
        while (cyc < 3000 && !ok) begin
            @(negedge i_clk);
            i_start = 1'b0;
            cyc++;
            ok = o_finished;
        end
    endtask

    task automatic apply(input string name, input vec_t t);
        int cyc;
        logic ok;
        run(t.x, t.y, t.z, cyc, ok);
        chk({name, " finished"}, W'(ok), W'(1));
        chk({name, " x"}, o_x, t.ex);
        chk({name, " y"}, o_y, t.ey);
        chk({name, " err"}, W'(o_err), W'(t.eerr));
        if (t.ecyc != 0) chk({name, " cycle"}, W'(cyc), W'(t.ecyc));
        @(negedge i_clk);
        chk({name, " pulse"}, W'({o_finished, o_busy}), W'(0));
    endtask

    initial begin
        int cyc;
        int fin;
        logic ok;
        logic [W-1:0] z;
        vec_t t;

        vecs.push_back(mk(W'(9), W'(5), W'(1), W'(9), W'(5), 1'b0, 515));
        vecs.push_back(mk(W'(4), W'(6), W'(2), W'(2), W'(3), 1'b0, 0));
        vecs.push_back(mk(P - W'(1), P - W'(1), P - W'(1), W'(1), W'(1), 1'b0, 0));
        vecs.push_back(mk(W'(7), W'(8), P + W'(1), W'(7), W'(8), 1'b0, 515));
        vecs.push_back(mk(W'(3), W'(4), W'(0), W'(0), W'(0), 1'b1, 2));
        vecs.push_back(mk(W'(3), W'(4), P, W'(0), W'(0), 1'b1, 2));
        vecs.push_back(mk(P + W'(5), {W{1'b1}}, W'(1), W'(5), W'(18), 1'b0, 515));
        vecs.push_back(mk(W'(1), W'(0), W'(2), (P + W'(1)) >> 1, W'(0), 1'b0, 0));
        vecs.push_back(mk(BX, BY, W'(1), BX, BY, 1'b0, 515));
        for (int i = 0; i < 2; i++) begin
            z = red(rnd());
            vecs.push_back(mk(mulmod(BX, z), mulmod(BY, z), z, BX, BY, 1'b0, 0));
        end
        for (int i = 0; i < 3; i++) vecs.push_back(model(rnd(), rnd(), rnd()));

        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("reset x", o_x, W'(0));
        chk("reset y", o_y, W'(1));
        chk("reset flags", W'({o_finished, o_err, o_busy}), W'(0));

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // i_start while inverting must not disturb the running conversion
        @(negedge i_clk);
        i_x = W'(11); i_y = W'(13); i_z = W'(12345); i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        chk("busy mid inv", W'(o_busy), W'(1));
        i_x = W'(99); i_y = W'(98); i_z = W'(1); i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 0;
        while (cyc < 3000 && !o_finished) begin
            @(negedge i_clk);
            cyc++;
        end
        t = model(W'(11), W'(13), W'(12345));
        chk("ignore start finished", W'(o_finished), W'(1));
        chk("ignore start x", o_x, t.ex);
        chk("ignore start y", o_y, t.ey);
        repeat (5) @(negedge i_clk);
        chk("hold x", o_x, t.ex);

        // reset while the first product is running
        @(negedge i_clk);
        i_x = W'(21); i_y = W'(22); i_z = W'(1); i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (100) @(negedge i_clk);
        chk("busy mid mul", W'(o_busy), W'(1));
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mid reset x", o_x, W'(0));
        chk("mid reset y", o_y, W'(1));
        chk("mid reset flags", W'({o_finished, o_err, o_busy}), W'(0));
        fin = 0;
        repeat (600) begin
            @(negedge i_clk);
            if (o_finished) fin++;
        end
        chk("no finish after reset", W'(fin), W'(0));
        chk("reset y held", o_y, W'(1));

        t = model(W'(21), W'(22), W'(3));
        apply("after reset", t);
        run(W'(9), W'(5), W'(1), cyc, ok);
        chk("back to back cycle", W'(cyc), W'(515));
        chk("back to back x", o_x, W'(9));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/proj_to_affine.md
# proj_to_affine

Converts the projective Ed25519 point (X, Y, Z) produced by the scalar-multiplication stage into affine coordinates: x = X·Z⁻¹ mod p and y = Y·Z⁻¹ mod p, where p = 2^255 − 19. It sits directly downstream of the scalar multiplier and consumes that stage's `o_x`/`o_y`/`o_z`/`o_finished` unchanged. Z⁻¹ is computed by a one-step-per-cycle binary extended Euclid. The two products use a shared bit-serial modular multiplier.

## Interface
- `W`, default 255: coordinate width.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  one-cycle start pulse. Sampled only in S_IDLE; ignored otherwise.
- `i_x`, `i_y`, `i_z`  in  W  projective inputs. Any W-bit value is accepted.
- `o_x`, `o_y`  out  W  affine result, registered. Held until the next completion.
- `o_finished`  out  1  one-cycle pulse when a result (or error) is valid.
- `o_err`  out  1  valid with `o_finished`: asserted when Z ≡ 0 mod p.
- `o_busy`  out  1  high whenever the state is not S_IDLE.

## Operation
- **S_IDLE:** on `i_start`, capture each input reduced by one conditional subtract (v ≥ p ? v − p : v). Initialise u = Z, v = p, x1 = 1, x2 = 0. Go to S_INV.
- **S_INV:** one action per cycle, evaluated in priority order:
  - u == 0: Z ≡ 0. Set `o_x` = 0, `o_y` = 0, pulse `o_finished` and `o_err`. Go to S_IDLE.
  - u == 1: inv = x1. Start the multiplier on (X, inv). Go to S_MUL_X.
  - v == 1: inv = x2. Same action as the u == 1 case.
  - u even: u >>= 1; x1 = x1 even ? x1 >> 1 : (x1 + p) >> 1. Use a 256-bit intermediate.
  - v even: same update applied to v and x2.
  - u ≥ v: u −= v; x1 = x1 − x2 mod p (add p on borrow).
  - else: v −= u; x2 = x2 − x1 mod p.
- **S_MUL_X:** on multiplier done, latch the product as x. Start the multiplier on (Y, inv). Go to S_MUL_Y.
- **S_MUL_Y:** on done, update `o_x` with x and `o_y` with the product. Pulse `o_finished` with `o_err` = 0. Go to S_IDLE.
- **Invariants:** all intermediate values of x1, x2 and the products stay in [0, p−1]. Outputs are fully reduced.

## Timing
- **Reset values:** `o_x` = 0, `o_y` = 1 (affine identity), `o_finished` = 0, `o_err` = 0, `o_busy` = 0. State is S_IDLE.
- **Cycle numbering:** cycle 0 is the cycle in which `i_start` is sampled. Cycle 1 is the first S_INV cycle.
- **Inversion length:** I = the number of S_INV cycles, including the terminating one. I ≤ 1022.
- **mod_mul latency:** `o_done` rises exactly 256 cycles after its `i_start`. That is 1 load cycle plus 255 MSB-first iterations of acc = 2·acc mod p, then + a mod p when bit b[k] is set.
- **Normal completion:** `o_finished` is high in cycle I + 514. For Z ≡ 1, I = 1, so this is cycle 515.
- **Z ≡ 0:** `o_finished` and `o_err` are high in cycle 2.
- **Next start:** the earliest accepted `i_start` is the cycle after `o_finished`. Back-to-back operation through S_IDLE is supported.
- **`i_start` while busy:** ignored, with no effect on the running operation.
- **Reset mid-operation:** returns to S_IDLE with the reset values. No `o_finished` pulse, and the in-flight result is discarded.

## Structure
- **Package `ed25519_pkg`:**
  - `W`;
  - prime `P` (255-bit);
  - `p2a_state_t` enum {S_IDLE, S_INV, S_MUL_X, S_MUL_Y};
  - a shared `mod_sub` function that adds p on borrow.
- **Sub-module `mod_mul`:**
  - Ports: `i_clk`, `i_rst`, `i_start`, `i_a`, `i_b`, `o_p`, `o_done`.
  - Bit-serial Montgomery-free interleaved multiplier as specified above.
  - One instance, reused for both products.
- **Top module:** contains the FSM, the u/v/x1/x2 registers and the output registers.

## Test plan
- X = 9, Y = 5, Z = 1 → (9, 5), `o_err` = 0, `o_finished` in cycle 515.
- X = 4, Y = 6, Z = 2 → (2, 3).
- X = Y = Z = p − 1 → (1, 1).
- Z = p + 1 (captured as 1), X = 7, Y = 8 → (7, 8).
- Z = 0 → `o_err` = 1, output (0, 0), `o_finished` in cycle 2.
- Base point chained from the scalar-multiplier stage:
  - M = 1 → affine output equals the base point.
  - Random M → result matches a golden model.
- Robustness:
  - `i_start` pulsed mid-S_INV is ignored.
  - `i_rst` asserted mid-S_MUL_X → reset values and no `o_finished`.
  - A fresh run afterwards gives the correct result.
